// File: rtl/bs_pkg.sv
// Shared bus-system definitions used by bs_drvr_fifo and bs_gnrtr: packet
// width default, broadcast target and packet field offsets.
package bs_pkg;

  localparam int unsigned PCKG_SZ_DFLT = 32;
  localparam int unsigned FIELD_W      = 8;

  localparam logic [FIELD_W-1:0] BROADCAST = 8'hFF;

  // Field offsets for a default-width packet: {target, source, id}
  localparam int unsigned TRGT_MSB = PCKG_SZ_DFLT - 1;
  localparam int unsigned TRGT_LSB = PCKG_SZ_DFLT - FIELD_W;
  localparam int unsigned SRC_MSB  = TRGT_LSB - 1;
  localparam int unsigned SRC_LSB  = TRGT_LSB - FIELD_W;
  localparam int unsigned ID_MSB   = SRC_LSB - 1;
  localparam int unsigned ID_LSB   = 0;

  typedef struct packed {
    logic [FIELD_W-1:0]           trgt;
    logic [FIELD_W-1:0]           src;
    logic [PCKG_SZ_DFLT-2*FIELD_W-1:0] id;
  } bs_pckt_t;

  function automatic logic [FIELD_W-1:0] pckt_trgt(input logic [PCKG_SZ_DFLT-1:0] p);
    return p[TRGT_MSB:TRGT_LSB];
  endfunction

endpackage

// File: rtl/bs_fifo_mem.sv
// Queue storage: DEPTH x PCKG_SZ register array, one synchronous write port
// and one asynchronous read port. Contents are not reset.
module bs_fifo_mem #(
  parameter int unsigned PCKG_SZ = 32,
  parameter int unsigned DEPTH   = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [PCKG_SZ-1:0]       wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [PCKG_SZ-1:0]       rdata
);

  logic [PCKG_SZ-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/bs_drvr_fifo.sv
// First-word-fall-through driver queue between a device and the bus generator.
// Define BS_FIFO_OVRWRT_EN to make a push into a full queue drop the oldest entry.
module bs_drvr_fifo
  import bs_pkg::*;
#(
  parameter int unsigned PCKG_SZ = PCKG_SZ_DFLT,
  parameter int unsigned DEPTH   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [PCKG_SZ-1:0]     D_push,
  input  logic                   pop,
  output logic [PCKG_SZ-1:0]     D_pop,
  output logic                   pndng,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   ovrflw
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      count_q;
  logic               ovrflw_q;
  logic [PCKG_SZ-1:0] mem_rdata;

  logic pop_ok, push_ok, ovf_push;
  logic wr_en, rd_adv;
  logic [CW-1:0] count_nxt;

  // Flags derive from registered occupancy only
  assign pndng  = (count_q != '0);
  assign full   = (count_q == CW'(DEPTH));
  assign count  = count_q;
  assign ovrflw = ovrflw_q;

  always_comb begin
    pop_ok   = pop & pndng;
    // A pop on a full queue frees the slot the push lands in
    push_ok  = push & (~full | pop);
    ovf_push = push & full & ~pop;
`ifdef BS_FIFO_OVRWRT_EN
    wr_en    = push_ok | ovf_push;
    rd_adv   = pop_ok | ovf_push;
`else
    wr_en    = push_ok;
    rd_adv   = pop_ok;
`endif
    count_nxt = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_nxt = count_q + CW'(1);
      2'b01:   count_nxt = count_q - CW'(1);
      default: count_nxt = count_q;
    endcase
  end

  // Pointer widths are log2(DEPTH), so increments wrap naturally
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      ovrflw_q <= 1'b0;
    end else begin
      if (wr_en)  wr_ptr <= wr_ptr + AW'(1);
      if (rd_adv) rd_ptr <= rd_ptr + AW'(1);
      count_q  <= count_nxt;
      ovrflw_q <= ovrflw_q | ovf_push;
    end
  end

  bs_fifo_mem #(
    .PCKG_SZ (PCKG_SZ),
    .DEPTH   (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (D_push),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

  assign D_pop = pndng ? mem_rdata : '0;

endmodule

// File: tb/tb_bs_drvr_fifo.sv
// Directed bench for bs_drvr_fifo (DEPTH=16, PCKG_SZ=32); expectations follow
// BS_FIFO_OVRWRT_EN when it is defined for the build.
module tb_bs_drvr_fifo;

  localparam int unsigned PW = 32;
  localparam int unsigned DP = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          push;
  logic [PW-1:0] D_push;
  logic          pop;
  logic [PW-1:0] D_pop;
  logic          pndng;
  logic          full;
  logic [4:0]    count;
  logic          ovrflw;

  int total = 0;
  int bad   = 0;

  logic [PW-1:0] q[$];

  typedef struct {
    logic          push;
    logic          pop;
    logic [PW-1:0] d;
    logic          e_pndng;
    logic          e_full;
    int            e_count;
    logic [PW-1:0] e_dpop;
    logic          e_ovf;
  } vec_t;

  vec_t vecs[8];

  bs_drvr_fifo #(.PCKG_SZ(PW), .DEPTH(DP)) dut (
    .clk    (clk),
    .reset  (reset),
    .push   (push),
    .D_push (D_push),
    .pop    (pop),
    .D_pop  (D_pop),
    .pndng  (pndng),
    .full   (full),
    .count  (count),
    .ovrflw (ovrflw)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic p, input logic o, input logic [PW-1:0] d);
    push = p; pop = o; D_push = d;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0;
  endtask

  // Reference queue update for non-reset cycles
  task automatic model(input logic p, input logic o, input logic [PW-1:0] d);
    bit was_full = (q.size() == DP);
    bit was_pnd  = (q.size() != 0);
    if (o && was_pnd) void'(q.pop_front());
    if (p) begin
      if (!was_full || o) q.push_back(d);
`ifdef BS_FIFO_OVRWRT_EN
      else begin void'(q.pop_front()); q.push_back(d); end
`endif
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".count"}, PW'(count), PW'(q.size()));
    chk({tag, ".pndng"}, PW'(pndng), PW'(q.size() != 0));
    chk({tag, ".full"},  PW'(full),  PW'(q.size() == DP));
    chk({tag, ".dpop"},  D_pop, (q.size() != 0) ? q[0] : '0);
  endtask

  task automatic go(input logic p, input logic o, input logic [PW-1:0] d, input string tag);
    step(p, o, d);
    model(p, o, d);
    chk_model(tag);
  endtask

  initial begin
    reset = 1'b0; push = 1'b0; pop = 1'b0; D_push = '0;
    vecs[0] = '{1'b1, 1'b0, 32'h0100_0000, 1'b1, 1'b0, 1, 32'h0100_0000, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 32'h0,         1'b0, 1'b0, 0, 32'h0,         1'b0};
    vecs[2] = '{1'b0, 1'b1, 32'h0,         1'b0, 1'b0, 0, 32'h0,         1'b0};
    vecs[3] = '{1'b1, 1'b1, 32'h0203_00AA, 1'b1, 1'b0, 1, 32'h0203_00AA, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 32'h0203_00BB, 1'b1, 1'b0, 2, 32'h0203_00AA, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 32'hFF01_00CC, 1'b1, 1'b0, 2, 32'h0203_00BB, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 32'h0,         1'b1, 1'b0, 1, 32'hFF01_00CC, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 32'h0,         1'b0, 1'b0, 0, 32'h0,         1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst.count",  PW'(count),  '0);
    chk("rst.pndng",  PW'(pndng),  '0);
    chk("rst.full",   PW'(full),   '0);
    chk("rst.ovrflw", PW'(ovrflw), '0);
    chk("rst.dpop",   D_pop,       '0);
    reset = 1'b1;

    for (int i = 0; i < 8; i++) begin
      step(vecs[i].push, vecs[i].pop, vecs[i].d);
      chk($sformatf("vec%0d.pndng", i), PW'(pndng),  PW'(vecs[i].e_pndng));
      chk($sformatf("vec%0d.full", i),  PW'(full),   PW'(vecs[i].e_full));
      chk($sformatf("vec%0d.count", i), PW'(count),  PW'(vecs[i].e_count));
      chk($sformatf("vec%0d.dpop", i),  D_pop,       vecs[i].e_dpop);
      chk($sformatf("vec%0d.ovrflw", i), PW'(ovrflw), PW'(vecs[i].e_ovf));
    end

    // Fill with IDs 0..15
    q.delete();
    for (int i = 0; i < DP; i++) go(1'b1, 1'b0, 32'h0201_0000 | PW'(i), $sformatf("fill%0d", i));
    chk("fill.full",  PW'(full),  32'd1);
    chk("fill.count", PW'(count), 32'd16);
    chk("fill.dpop",  D_pop,      32'h0201_0000);

    // Push into a full queue without pop
    go(1'b1, 1'b0, 32'hFFFF_0010, "ovf");
    chk("ovf.ovrflw", PW'(ovrflw), 32'd1);
`ifdef BS_FIFO_OVRWRT_EN
    chk("ovf.head", D_pop, 32'h0201_0001);
`else
    chk("ovf.head", D_pop, 32'h0201_0000);
`endif

    // Push and pop together while full
    go(1'b1, 1'b1, 32'h0405_0077, "fullpp");
    chk("fullpp.ovrflw", PW'(ovrflw), 32'd1);

    // Drain in order, then one pop on empty
    for (int i = 0; i < DP; i++) go(1'b0, 1'b1, '0, $sformatf("drain%0d", i));
    go(1'b0, 1'b1, '0, "popempty");
    chk("popempty.ovrflw", PW'(ovrflw), 32'd1);

    // Count=5 then 40 cycles of simultaneous push/pop across pointer wrap
    for (int i = 0; i < 5; i++) go(1'b1, 1'b0, 32'h0A0B_1000 | PW'(i), $sformatf("pre%0d", i));
    for (int i = 0; i < 40; i++) go(1'b1, 1'b1, 32'h0C0D_2000 | PW'(i), $sformatf("pp%0d", i));
    chk("pp.count", PW'(count), 32'd5);

    // Reach count=7 with ovrflw still set, then reset with push asserted
    go(1'b1, 1'b0, 32'h1111_0001, "c6");
    go(1'b1, 1'b0, 32'h1111_0002, "c7");
    chk("c7.ovrflw", PW'(ovrflw), 32'd1);
    reset = 1'b0;
    step(1'b1, 1'b0, 32'h2222_0003);
    reset = 1'b1;
    q.delete();
    chk("mrst.count",  PW'(count),  '0);
    chk("mrst.pndng",  PW'(pndng),  '0);
    chk("mrst.ovrflw", PW'(ovrflw), '0);
    chk("mrst.dpop",   D_pop,       '0);
    go(1'b0, 1'b0, '0, "postrst");
    go(1'b1, 1'b0, 32'h3333_0004, "postpush");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
